fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the SRAM-backed asynchronous FIFO between `NUM_REQ` producers in the `fifo_wr_clk` domain. Each producer streams bursts over a valid/ready/last handshake. The arbiter grants one producer per burst and steers its data onto `fifo_wr`/`fifo_wdata`. It never issues a write while `fifo_full` is high, so no beat is ever dropped by the FIFO.

---
 rtl/fifo_wr_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and limits for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

  // Upper bound on producers sharing one write port.
  localparam int MAX_NUM_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority search: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    int unsigned w_pos;
    o_idx = '0;
    o_any = |i_req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_pos]) o_idx = ID_W'(w_pos);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// state | meaning
// IDLE  | no grant; pick next producer from rr_ptr (one dead cycle per burst)
// BURST | granted producer streams beats until last or forced split
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FIFO_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                        fifo_wr_clk,
  input  logic                        wrclk_RESET_N,
  input  logic                        wr_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*FIFO_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [FIFO_W-1:0]           fifo_wdata,
  output logic                        grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [31:0]                 beat_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end

  arb_state_t        r_state, w_state_nxt;
  logic [ID_W-1:0]   r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BC_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
  logic [31:0]       r_beat_cnt;

  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_gnt_valid, w_gnt_last;
  logic [FIFO_W-1:0] w_gnt_data;
  logic              w_beat, w_burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Select the granted producer's lane.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_gnt_valid = req_valid[i];
        w_gnt_last  = req_last[i];
        w_gnt_data  = req_data[i*FIFO_W +: FIFO_W];
      end
    end
  end

  // fifo_full is sampled combinationally so a full FIFO blocks the beat in the same cycle.
  assign w_beat      = (r_state == BURST) & wr_en & w_gnt_valid & ~fifo_full;
  assign w_burst_end = w_beat & (w_gnt_last | (r_burst_cnt == BC_W'(MAX_BURST - 1)));

  // Next-state, grant and pointer update; everything holds unless enabled.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (wr_en && w_pick_any) begin
          w_state_nxt     = BURST;
          w_grant_id_nxt  = w_pick_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (w_beat) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
          if (w_burst_end) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write-port outputs; data is zeroed whenever no beat transfers.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_beat && (r_grant_id == ID_W'(i));
    end
    fifo_wr    = w_beat;
    fifo_wdata = w_beat ? w_gnt_data : '0;
  end

  // State and counter registers; reset abandons any partial burst.
  always_ff @(posedge fifo_wr_clk or negedge wrclk_RESET_N) begin
    if (!wrclk_RESET_N) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_beat) r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign grant_vld = (r_state == BURST);
  assign grant_id  = r_grant_id;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive the DUT, a burst-level model predicts outputs.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 16;

  typedef logic [63:0] q64_t[$];

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic           full = 1'b0;
  logic [N-1:0]   valid, last, ready;
  logic [N*W-1:0] data;
  logic           fwr;
  logic [W-1:0]   wdata;
  logic           gvld;
  logic [1:0]     gid;
  logic [31:0]    bcnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_W(W), .MAX_BURST(MB)) dut (
    .fifo_wr_clk   (clk),
    .wrclk_RESET_N (rst_n),
    .wr_en         (wr_en),
    .req_valid     (valid),
    .req_last      (last),
    .req_data      (data),
    .req_ready     (ready),
    .fifo_full     (full),
    .fifo_wr       (fwr),
    .fifo_wdata    (wdata),
    .grant_vld     (gvld),
    .grant_id      (gid),
    .beat_cnt      (bcnt)
  );

  int tests = 0;
  int fails = 0;

  // Producers: a beat is offered while its queue is non-empty and popped only when accepted.
  logic [W-1:0] q_data[N][$];
  bit           q_last[N][$];

  // Reference: who owns the port (-1 = none), rotation pointer, beats in burst, total.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_gid   = 0;
  int          m_cnt   = 0;
  logic [31:0] m_total = 0;

  q64_t wr_log;
  q64_t grant_log;
  q64_t grant_cyc;
  bit   prev_gvld = 1'b0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input q64_t got, input q64_t exp);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
  endtask

  task automatic push_burst(input int p, input int len, input logic [W-1:0] base, input bit with_last);
    for (int k = 0; k < len; k++) begin
      q_data[p].push_back(base + W'(k));
      q_last[p].push_back(with_last && (k == len - 1));
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      valid[i] = (q_data[i].size() > 0);
      last[i]  = valid[i] ? q_last[i][0] : 1'b0;
      data[i*W +: W] = valid[i] ? q_data[i][0] : '0;
    end
  endtask

  task automatic check_reset_values();
    check("rst_fifo_wr", 64'(fwr), 64'(0));
    check("rst_req_ready", 64'(ready), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_grant_vld", 64'(gvld), 64'(0));
    check("rst_grant_id", 64'(gid), 64'(0));
    check("rst_beat_cnt", 64'(bcnt), 64'(0));
  endtask

  // One clock: drive, compare against the model, clock, advance the model.
  task automatic step();
    bit           beat;
    bit           found;
    bit           l;
    int           pick;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] d;
    drive_inputs();
    #3;
    beat    = (m_owner >= 0) && wr_en && valid[m_owner] && !full;
    exp_rdy = '0;
    if (beat) exp_rdy[m_owner] = 1'b1;
    check("fifo_wr", 64'(fwr), 64'(beat));
    check("fifo_wdata", 64'(wdata), beat ? 64'(q_data[m_owner][0]) : 64'(0));
    check("req_ready", 64'(ready), 64'(exp_rdy));
    check("grant_vld", 64'(gvld), 64'(m_owner >= 0));
    check("grant_id", 64'(gid), 64'(m_gid));
    check("beat_cnt", 64'(bcnt), 64'(m_total));
    if (fwr === 1'b1) wr_log.push_back(64'(wdata));
    if (gvld === 1'b1 && !prev_gvld) begin
      grant_log.push_back(64'(gid));
      grant_cyc.push_back(64'(cyc));
    end
    prev_gvld = (gvld === 1'b1);
    @(posedge clk);
    cyc++;
    if (m_owner < 0) begin
      if (wr_en && (|valid)) begin
        found = 1'b0;
        pick  = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && valid[(m_ptr + k) % N]) begin
            found = 1'b1;
            pick  = (m_ptr + k) % N;
          end
        end
        m_owner = pick;
        m_gid   = pick;
        m_cnt   = 0;
      end
    end else if (beat) begin
      l = q_last[m_owner].pop_front();
      d = q_data[m_owner].pop_front();
      m_cnt++;
      m_total++;
      if (l || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (q_data[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (busy() && c < budget) begin
      step();
      c++;
    end
    check({tag, "_drain_timeout"}, 64'(c >= budget), 64'(0));
    step();
  endtask

  // Asynchronous reset pulse at any point; outputs must clear without a clock edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_cnt   = 0;
    m_total = 0;
    prev_gvld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  initial begin
    q64_t exp;
    int   p;
    wr_en = 1'b1;
    full  = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Single producer, three beats.
    clear_logs();
    q_data[0].push_back(64'hA0); q_last[0].push_back(1'b0);
    q_data[0].push_back(64'hA1); q_last[0].push_back(1'b0);
    q_data[0].push_back(64'hA2); q_last[0].push_back(1'b1);
    run_idle("single", 20);
    exp = '{64'hA0, 64'hA1, 64'hA2};
    check_log("single_data", wr_log, exp);
    exp = '{64'd0};
    check_log("single_grant", grant_log, exp);
    check("single_beat_cnt", 64'(bcnt), 64'd3);
    check("single_gap", grant_cyc.size() > 0 ? grant_cyc[0] : 64'hFFFF, 64'd1);

    // Pointer moved to 1: with 0 and 1 both asking, 1 wins first.
    clear_logs();
    push_burst(0, 1, 64'hB0, 1'b1);
    push_burst(1, 1, 64'hB1, 1'b1);
    run_idle("ptr", 20);
    exp = '{64'd1, 64'd0};
    check_log("ptr_grant", grant_log, exp);

    // Fairness with 2-beat bursts from all producers.
    async_reset();
    clear_logs();
    for (int i = 0; i < N; i++) begin
      push_burst(i, 2, 64'hC00 + 64'(i * 16), 1'b1);
      push_burst(i, 2, 64'hD00 + 64'(i * 16), 1'b1);
    end
    run_idle("fair", 60);
    exp = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd0, 64'd1, 64'd2, 64'd3};
    check_log("fair_grant", grant_log, exp);
    for (int i = 1; i < 5 && i < grant_cyc.size(); i++)
      check("fair_period", grant_cyc[i] - grant_cyc[i-1], 64'd3);

    // Forced split at MAX_BURST with another producer waiting.
    async_reset();
    clear_logs();
    push_burst(2, 20, 64'h200, 1'b0);
    push_burst(3, 1, 64'h300, 1'b1);
    run(28);
    exp = '{64'd2, 64'd3, 64'd2};
    check_log("split_grant", grant_log, exp);
    exp = {};
    for (int k = 0; k < 16; k++) exp.push_back(64'h200 + 64'(k));
    exp.push_back(64'h300);
    for (int k = 16; k < 20; k++) exp.push_back(64'h200 + 64'(k));
    check_log("split_data", wr_log, exp);

    // Last coinciding with the MAX_BURST-th beat: one burst only.
    async_reset();
    clear_logs();
    push_burst(0, 16, 64'h400, 1'b1);
    run_idle("last16", 40);
    check("last16_grants", 64'(grant_log.size()), 64'd1);
    check("last16_beats", 64'(bcnt), 64'd16);

    // Backpressure: fifo_full held for 5 cycles mid-burst.
    async_reset();
    clear_logs();
    push_burst(1, 6, 64'h100, 1'b1);
    run(3);
    full = 1'b1;
    run(5);
    full = 1'b0;
    run_idle("bp", 20);
    exp = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105};
    check_log("bp_data", wr_log, exp);

    // Clock enable low for 3 cycles mid-burst.
    clear_logs();
    push_burst(3, 5, 64'h500, 1'b1);
    run(2);
    wr_en = 1'b0;
    run(3);
    check("wren_hold_vld", 64'(gvld), 64'd1);
    check("wren_hold_cnt", 64'(bcnt), 64'd7);
    wr_en = 1'b1;
    run_idle("wren", 20);
    exp = '{64'h500, 64'h501, 64'h502, 64'h503, 64'h504};
    check_log("wren_data", wr_log, exp);

    // Reset mid-burst: partial burst abandoned, next grant starts at producer 0.
    async_reset();
    push_burst(0, 1, 64'h600, 1'b1);
    run_idle("pre_rst", 10);
    clear_logs();
    push_burst(1, 4, 64'h610, 1'b1);
    push_burst(0, 2, 64'h620, 1'b1);
    run(3);
    check("mid_rst_owner", 64'(gid), 64'd1);
    async_reset();
    clear_logs();
    run_idle("post_rst", 30);
    check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : 64'hFFFF, 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      wr_en = ($urandom_range(0, 9) != 0);
      full  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) begin
        p = int'($urandom_range(0, N - 1));
        if (q_data[p].size() < 24)
          push_burst(p, int'($urandom_range(1, 20)), W'({$urandom, $urandom}), 1'b1);
      end
      step();
    end
    wr_en = 1'b1;
    full  = 1'b0;
    run_idle("rand", 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
